memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Responder end of the CPU memory-request interface: accepts instruction fetch requests (iREN/iaddr) and data requests (dREN/dWEN/daddr/dstore) from the datapath request logic.
- Serialises them onto a single-ported RAM with variable latency (ramstate handshake).
- Returns one-cycle ihit/dhit pulses with the loaded word.
- Sits between the CPU datapath and the RAM model/cache-less memory.

Parameters:
- WORD_W, 32, width of addresses and data words
- TIMEOUT, 16, max cycles an access waits for ramstate==ACCESS before abort/retry (≥2)
- ERRCNT_W, 8, width of saturating error counter

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- iREN  in  1  instruction read request (level, held until ihit)
- iaddr  in  WORD_W  instruction address
- dREN  in  1  data read request (level, held until dhit)
- dWEN  in  1  data write request (level, held until dhit)
- daddr  in  WORD_W  data address
- dstore  in  WORD_W  data write value
- ihit  out  1  one-cycle instruction completion pulse
- dhit  out  1  one-cycle data completion pulse
- iload  out  WORD_W  fetched instruction, valid in ihit cycle, held afterwards
- dload  out  WORD_W  loaded data, valid in dhit cycle (read only), held afterwards
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data, valid when ramstate==ACCESS
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- err_cnt  out  ERRCNT_W  count of aborted accesses (ERROR or timeout), saturating

Behaviour:
- Reset (async): state=IDLE; ihit, dhit, ramREN, ramWEN = 0; ramaddr, ramstore, iload, dload = 0; wait counter = 0; err_cnt = 0.
- States:
  - IDLE: no strobes.
    - If dREN|dWEN: latch daddr, dstore, op (write if dWEN); go to DACCESS.
    - Else if iREN: latch iaddr; go to IFETCH.
    - Data has strict priority. Starvation is prevented by the requester dropping d-requests after dhit.
  - IFETCH: ramREN=1, ramaddr=latched address.
  - DACCESS: ramREN=~op, ramWEN=op, ramaddr/ramstore from latched values.
  - In IFETCH/DACCESS, wait counter increments each cycle.
    - ramstate==ACCESS: capture ramload into iload (IFETCH) or dload (DACCESS read; dload unchanged on write); go to HIT.
    - ramstate==ERROR, or counter reaches TIMEOUT-1 with no ACCESS: err_cnt+1 (saturates at all-ones); go to BACKOFF.
    - ACCESS takes precedence over timeout in the same cycle.
  - HIT: exactly one cycle. ihit=1 if the completed access was IFETCH, else dhit=1. Strobes 0. Next state IDLE.
  - BACKOFF: one cycle, strobes 0, no hit. Next state IDLE, which re-arbitrates (retry).
- Strobe/hit outputs are registered (decoded from the state register); no combinational path from CPU inputs to RAM outputs.
- Latency: from request sampled in IDLE to hit is 1 (IDLE→access) + N cycles until ACCESS + 1 (HIT). Minimum is 3 cycles when the RAM returns ACCESS on the first access cycle.
- Minimum 1-cycle gap with strobes low between consecutive RAM accesses (HIT/BACKOFF → IDLE), so the RAM sees distinct transactions.
- Request inputs are ignored outside IDLE. A withdrawn request mid-access still completes and pulses its hit.
- dREN and dWEN both high: treated as a write.
- Wait counter clears on entry to IFETCH/DACCESS. Its width is clog2(TIMEOUT)+1.
- Reset asserted mid-access: immediate return to IDLE, strobes drop asynchronously, and no hit is produced.

Test Plan:
- iREN=1, iaddr=0x0000_0040, RAM returns ACCESS on 2nd access cycle with ramload=0x2408_0001 → ramREN high 2 cycles at ramaddr 0x40; ihit pulses 1 cycle, 4 cycles after request; iload=0x2408_0001; dhit never asserts.
- dWEN=1 and iREN=1 simultaneously, daddr=0x100, dstore=0xDEAD_BEEF, immediate ACCESS → ramWEN first with ramaddr=0x100 and ramstore=0xDEADBEEF; dhit pulse; then iREN held high → separate ramREN access after a ≥1-cycle strobe-low gap; then ihit.
- dREN=1, daddr=0x200, ramstate stays BUSY → after TIMEOUT(16) access cycles, strobes drop for 1 cycle (BACKOFF); err_cnt 0→1; access retried; then ACCESS with ramload=0x1234_5678 → dhit, dload=0x12345678.
- ramstate=ERROR on first access cycle for 300 consecutive attempts (ERRCNT_W=8) → err_cnt saturates at 255; no hit during errors; first subsequent ACCESS produces a single hit.
- nRST pulled low while in DACCESS (ramWEN=1) → ramWEN/ramREN=0 immediately; err_cnt=0; no dhit; after release with dWEN still high, the access restarts from IDLE.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// CPU-request / RAM bus bundle for the memory arbiter.
// slave is the arbiter's view; master is the requester-and-RAM side.
interface memory_arbiter_if #(
  parameter int WORD_W   = 32,
  parameter int ERRCNT_W = 8
);
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              ihit;
  logic              dhit;
  logic [WORD_W-1:0] iload;
  logic [WORD_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [1:0]        ramstate;
  logic [ERRCNT_W-1:0] err_cnt;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err_cnt
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err_cnt
  );
endinterface

// File: rtl/memory_arbiter.sv
// Serialises instruction and data requests onto a single-ported RAM with a
// variable-latency handshake; data wins arbitration, aborts retry via IDLE.
module memory_arbiter #(
  parameter int WORD_W   = 32,
  parameter int TIMEOUT  = 16,
  parameter int ERRCNT_W = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  memory_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IFETCH  = 3'd1,
    DACCESS = 3'd2,
    HIT     = 3'd3,
    BACKOFF = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   store_q, store_d;
  logic [WORD_W-1:0]   iload_q, iload_d;
  logic [WORD_W-1:0]   dload_q, dload_d;
  logic                op_wr_q, op_wr_d;
  logic                is_i_q, is_i_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ERRCNT_W-1:0] err_q, err_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= {WORD_W{1'b0}};
      store_q <= {WORD_W{1'b0}};
      iload_q <= {WORD_W{1'b0}};
      dload_q <= {WORD_W{1'b0}};
      op_wr_q <= 1'b0;
      is_i_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      err_q   <= {ERRCNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      op_wr_q <= op_wr_d;
      is_i_q  <= is_i_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    iload_d = iload_q;
    dload_d = dload_q;
    op_wr_d = op_wr_q;
    is_i_d  = is_i_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        // dREN and dWEN together resolve to a write
        if (bus.dREN || bus.dWEN) begin
          addr_d  = bus.daddr;
          store_d = bus.dstore;
          op_wr_d = bus.dWEN;
          is_i_d  = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
          state_d = DACCESS;
        end else if (bus.iREN) begin
          addr_d  = bus.iaddr;
          op_wr_d = 1'b0;
          is_i_d  = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          state_d = IFETCH;
        end else begin
          state_d = IDLE;
        end
      end
      IFETCH, DACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.ramstate == RAM_ACCESS) begin
          if (is_i_q) begin
            iload_d = bus.ramload;
          end else if (!op_wr_q) begin
            dload_d = bus.ramload;
          end else begin
            dload_d = dload_q;
          end
          state_d = HIT;
        end else if ((bus.ramstate == RAM_ERROR) || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          err_d   = (err_q == {ERRCNT_W{1'b1}}) ? err_q : (err_q + ERRCNT_W'(1));
          state_d = BACKOFF;
        end else begin
          state_d = state_q;
        end
      end
      HIT:     state_d = IDLE;
      BACKOFF: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and hits decode only flop state, so reset drops them at once
  assign bus.ramREN   = (state_q == IFETCH) || ((state_q == DACCESS) && !op_wr_q);
  assign bus.ramWEN   = (state_q == DACCESS) && op_wr_q;
  assign bus.ihit     = (state_q == HIT) && is_i_q;
  assign bus.dhit     = (state_q == HIT) && !is_i_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.err_cnt  = err_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: a scripted RAM responder checks each
// transaction it sees, and a hit monitor checks each returned pulse.
module tb_memory_arbiter;
  logic CLK = 1'b0;
  logic nRST;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   req_cyc = 0;
  int   hit_cnt = 0;

  memory_arbiter_if bus ();

  memory_arbiter #(.WORD_W(32), .TIMEOUT(16), .ERRCNT_W(8)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] store;
    int          lat;     // >0: ACCESS on that cycle, 0: BUSY forever, <0: ERROR
    int          cycles;  // expected strobe cycles, <0 = don't care
    logic [31:0] rdata;
  } ram_txn_t;

  typedef struct {
    logic        is_i;
    logic [31:0] data;
    int          lat;     // cycles from request to hit, <0 = don't care
  } hit_t;

  ram_txn_t ram_q[$];
  hit_t     hit_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_ram(input logic we, input logic [31:0] addr, input logic [31:0] store,
                          input int lat, input int cycles, input logic [31:0] rdata);
    ram_txn_t t;
    t.we = we; t.addr = addr; t.store = store; t.lat = lat; t.cycles = cycles; t.rdata = rdata;
    ram_q.push_back(t);
  endtask

  task automatic push_hit(input logic is_i, input logic [31:0] data, input int lat);
    hit_t h;
    h.is_i = is_i; h.data = data; h.lat = lat;
    hit_q.push_back(h);
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_hits(input string tag, input int n, input int budget);
    int k = 0;
    while (hit_cnt < n && k < budget) begin
      step();
      k++;
    end
    check_val(tag, 32'(hit_cnt >= n), 32'd1);
  endtask

  // Scripted RAM: one queue entry per strobe burst
  initial begin
    ram_txn_t cur;
    bit active = 1'b0;
    int acyc = 0;
    bus.ramstate = 2'd0;
    bus.ramload  = 32'h0;
    cur.lat = 1; cur.cycles = -1; cur.rdata = 32'h0; cur.we = 1'b0; cur.addr = 32'h0; cur.store = 32'h0;
    forever begin
      @(negedge CLK);
      if (bus.ramREN || bus.ramWEN) begin
        if (!active) begin
          active = 1'b1;
          acyc = 0;
          if (ram_q.size() == 0) begin
            check_val("ram_unexpected_txn", 32'd1, 32'd0);
            cur.lat = 1; cur.cycles = -1; cur.rdata = 32'h0;
          end else begin
            cur = ram_q.pop_front();
            check_val("ram_op_wen", 32'(bus.ramWEN), 32'(cur.we));
            check_val("ram_op_ren", 32'(bus.ramREN), 32'(!cur.we));
            check_val("ram_addr", bus.ramaddr, cur.addr);
            if (cur.we) check_val("ram_store", bus.ramstore, cur.store);
          end
        end
        acyc++;
        if (cur.lat < 0) begin
          bus.ramstate = 2'd3;
        end else if (cur.lat > 0 && acyc == cur.lat) begin
          bus.ramstate = 2'd2;
          bus.ramload  = cur.rdata;
        end else begin
          bus.ramstate = 2'd1;
        end
      end else begin
        if (active && cur.cycles >= 0) check_val("ram_strobe_cycles", 32'(acyc), 32'(cur.cycles));
        active = 1'b0;
        bus.ramstate = 2'd0;
      end
    end
  end

  // Hit monitor
  initial begin
    hit_t e;
    forever begin
      @(negedge CLK);
      if (bus.ihit || bus.dhit) begin
        hit_cnt++;
        check_val("hit_both", 32'(bus.ihit && bus.dhit), 32'd0);
        if (hit_q.size() == 0) begin
          check_val("hit_unexpected", 32'd1, 32'd0);
        end else begin
          e = hit_q.pop_front();
          check_val("hit_kind_i", 32'(bus.ihit), 32'(e.is_i));
          check_val("hit_data", e.is_i ? bus.iload : bus.dload, e.data);
          if (e.lat >= 0) check_val("hit_latency", 32'(cyc - req_cyc), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST = 1'b0;
    bus.iREN = 1'b0; bus.iaddr = 32'h0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = 32'h0; bus.dstore = 32'h0;
    repeat (3) step();
    check_val("rst_ihit", 32'(bus.ihit), 32'd0);
    check_val("rst_dhit", 32'(bus.dhit), 32'd0);
    check_val("rst_ramREN", 32'(bus.ramREN), 32'd0);
    check_val("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    check_val("rst_ramaddr", bus.ramaddr, 32'h0);
    check_val("rst_ramstore", bus.ramstore, 32'h0);
    check_val("rst_iload", bus.iload, 32'h0);
    check_val("rst_dload", bus.dload, 32'h0);
    check_val("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    nRST = 1'b1;
    repeat (2) step();

    // Fetch, ACCESS on 2nd access cycle: IDLE + 2 access + HIT -> 3 edges after request
    bus.iREN = 1'b1; bus.iaddr = 32'h0000_0040;
    push_ram(1'b0, 32'h40, 32'h0, 2, 2, 32'h2408_0001);
    push_hit(1'b1, 32'h2408_0001, 3);
    req_cyc = cyc;
    wait_hits("t1_ihit", 1, 50);
    bus.iREN = 1'b0;
    step();

    // Simultaneous write and fetch: write wins, fetch follows after a gap
    bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD_BEEF;
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    push_ram(1'b1, 32'h100, 32'hDEAD_BEEF, 1, 1, 32'h0);
    push_ram(1'b0, 32'h44, 32'h0, 1, 1, 32'h8C01_0004);
    push_hit(1'b0, 32'h0, 2);
    push_hit(1'b1, 32'h8C01_0004, -1);
    req_cyc = cyc;
    wait_hits("t2_dhit", 2, 50);
    bus.dWEN = 1'b0;
    wait_hits("t2_ihit", 3, 50);
    bus.iREN = 1'b0;
    step();

    // Timeout after 16 BUSY cycles, backoff, retry succeeds
    bus.dREN = 1'b1; bus.daddr = 32'h200;
    push_ram(1'b0, 32'h200, 32'h0, 0, 16, 32'h0);
    push_ram(1'b0, 32'h200, 32'h0, 1, 1, 32'h1234_5678);
    push_hit(1'b0, 32'h1234_5678, 20);
    req_cyc = cyc;
    wait_hits("t3_dhit", 4, 100);
    bus.dREN = 1'b0;
    check_val("t3_err_cnt", 32'(bus.err_cnt), 32'd1);
    step();

    // 300 ERROR responses saturate the counter, then one good fetch
    bus.iREN = 1'b1; bus.iaddr = 32'h80;
    for (int i = 0; i < 300; i++) push_ram(1'b0, 32'h80, 32'h0, -1, 1, 32'h0);
    push_ram(1'b0, 32'h80, 32'h0, 1, 1, 32'hCAFE_0080);
    push_hit(1'b1, 32'hCAFE_0080, -1);
    wait_hits("t4_ihit", 5, 1500);
    bus.iREN = 1'b0;
    check_val("t4_err_sat", 32'(bus.err_cnt), 32'd255);
    check_val("t4_dload_held", bus.dload, 32'h1234_5678);
    step();

    // Reset mid-write, then the held request restarts
    bus.dWEN = 1'b1; bus.daddr = 32'h300; bus.dstore = 32'h55AA_0300;
    push_ram(1'b1, 32'h300, 32'h55AA_0300, 0, -1, 32'h0);
    begin
      int k = 0;
      while (!bus.ramWEN && k < 10) begin
        step();
        k++;
      end
    end
    check_val("t5_wen_seen", 32'(bus.ramWEN), 32'd1);
    repeat (3) step();
    nRST = 1'b0;
    #1;
    check_val("t5_rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    check_val("t5_rst_ramREN", 32'(bus.ramREN), 32'd0);
    check_val("t5_rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    check_val("t5_rst_dhit", 32'(bus.dhit), 32'd0);
    repeat (2) step();
    push_ram(1'b1, 32'h300, 32'h55AA_0300, 2, 2, 32'h0);
    push_hit(1'b0, 32'h0, -1);
    nRST = 1'b1;
    wait_hits("t5_dhit", 6, 50);
    bus.dWEN = 1'b0;
    repeat (4) step();
    check_val("t5_err_cnt", 32'(bus.err_cnt), 32'd0);
    check_val("end_ram_q_empty", 32'(ram_q.size()), 32'd0);
    check_val("end_hit_q_empty", 32'(hit_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
